// File: rtl/aes_round_ctrl_if.sv
// Host-side handshake and data bundle of the iterative AES-128 round sequencer.
// The master side is the block source/sink, the slave side is aes_round_ctrl.
interface aes_round_ctrl_if;
    logic         start;
    logic         ready;
    logic         abort;
    logic [127:0] plaintext;
    logic [127:0] key;
    logic [127:0] iv;
    logic         busy;
    logic         done;
    logic [127:0] ciphertext;
    logic [127:0] iv_out;
    logic [255:0] cipher_bundle;

    modport master (
        output start, abort, plaintext, key, iv,
        input  ready, busy, done, ciphertext, iv_out, cipher_bundle
    );

    modport slave (
        input  start, abort, plaintext, key, iv,
        output ready, busy, done, ciphertext, iv_out, cipher_bundle
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 sequencer: whitens an accepted block, then steps one shared
// combinational round unit through NR rounds, one round per clock.
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    aes_round_ctrl_if.slave         host,
    output logic [127:0]            key_out,
    input  logic [128*(NR+1)-1:0]   round_keys,
    output logic [127:0]            rnd_state,
    output logic [127:0]            rnd_key,
    output logic                    rnd_last,
    input  logic [127:0]            rnd_result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    localparam logic [3:0] LAST_RND = 4'(NR - 1);

    fsm_t         fsm_reg;
    logic [3:0]   rnd_reg;
    logic [127:0] state_reg;
    logic [127:0] key_reg;
    logic [127:0] iv_reg;
    logic [127:0] ct_reg;
    logic         ready_reg;
    logic         busy_reg;
    logic         done_reg;
    logic [127:0] whiten_next;

    // Round-key selector: slices beyond NR are tied off so the 4-bit counter
    // always lands on a defined entry.
    logic [127:0] rk_slice [16];

    for (genvar gi = 0; gi < 16; gi++) begin : g_rk
        if (gi < NR) begin : g_used
            assign rk_slice[gi] = round_keys[gi*128 +: 128];
        end else begin : g_pad
            assign rk_slice[gi] = '0;
        end
    end

    // The top slice is consumed by the whitening path outside this block.
    logic unused_top_slice;
    assign unused_top_slice = ^round_keys[NR*128 +: 128];

    assign whiten_next = host.plaintext ^ host.key ^ host.iv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm_reg   <= IDLE;
            rnd_reg   <= '0;
            state_reg <= '0;
            key_reg   <= '0;
            iv_reg    <= '0;
            ct_reg    <= '0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (host.start) begin
                        state_reg <= whiten_next;
                        key_reg   <= host.key;
                        iv_reg    <= host.iv;
                        rnd_reg   <= '0;
                        fsm_reg   <= ROUND;
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b1;
                    end
                end

                ROUND: begin
                    // Abort wins even on the final round so a cancelled block
                    // never produces a done pulse or touches the ciphertext.
                    if (host.abort) begin
                        rnd_reg   <= '0;
                        fsm_reg   <= IDLE;
                        ready_reg <= 1'b1;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= rnd_result;
                        if (rnd_reg == LAST_RND) begin
                            ct_reg   <= rnd_result;
                            fsm_reg  <= DONE;
                            busy_reg <= 1'b0;
                            done_reg <= 1'b1;
                        end else begin
                            rnd_reg <= rnd_reg + 4'd1;
                        end
                    end
                end

                DONE: begin
                    fsm_reg   <= IDLE;
                    done_reg  <= 1'b0;
                    ready_reg <= 1'b1;
                end

                default: begin
                    fsm_reg   <= IDLE;
                    rnd_reg   <= '0;
                    ready_reg <= 1'b1;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign rnd_state = state_reg;
    assign rnd_key   = rk_slice[rnd_reg];
    assign rnd_last  = (fsm_reg == ROUND) && (rnd_reg == LAST_RND);
    assign key_out   = key_reg;

    assign host.ready         = ready_reg;
    assign host.busy          = busy_reg;
    assign host.done          = done_reg;
    assign host.ciphertext    = ct_reg;
    assign host.iv_out        = iv_reg;
    assign host.cipher_bundle = {iv_reg, ct_reg};

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl; supplies a behavioural round unit and key
// expansion around the sequencer and checks results against FIPS-197 C.1.
module tb_aes_round_ctrl;

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk;
    logic          rst;
    logic [127:0]  key_out;
    logic [1407:0] round_keys;
    logic [127:0]  rnd_state;
    logic [127:0]  rnd_key;
    logic          rnd_last;
    logic [127:0]  rnd_result;

    int tests = 0;
    int fails = 0;

    logic [7:0] sbox [256];
    logic       sbox_ok = 1'b0;

    aes_round_ctrl_if h ();

    aes_round_ctrl #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .host       (h),
        .key_out    (key_out),
        .round_keys (round_keys),
        .rnd_state  (rnd_state),
        .rnd_key    (rnd_key),
        .rnd_last   (rnd_last),
        .rnd_result (rnd_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=stuck expected=summary");
        $fatal(1, "bench time limit expired");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return p;
    endfunction

    // Slices 0..9 carry round keys 1..10; slice 10 carries round key 0.
    function automatic logic [1407:0] expand(input logic [127:0] k);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] o;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        o = '0;
        for (int r = 1; r <= 10; r++) o[(r-1)*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        o[1280 +: 128] = {w[0], w[1], w[2], w[3]};
        return o;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk, input logic last);
        logic [7:0]   b [16];
        logic [7:0]   s [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox[st[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[4*c+r] = b[4*((c+r)%4)+r];
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                     a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                     a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                     xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
            end
        end
        return o ^ rk;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] p, input logic [127:0] k, input logic [127:0] v);
        logic [1407:0] ks;
        logic [127:0]  st;
        ks = expand(k);
        st = p ^ k ^ v;
        for (int r = 0; r < 10; r++) st = aes_round(st, ks[r*128 +: 128], r == 9);
        return st;
    endfunction

    always_comb begin
        round_keys = '0;
        if (sbox_ok) round_keys = expand(key_out);
    end

    always_comb begin
        rnd_result = '0;
        if (sbox_ok) rnd_result = aes_round(rnd_state, rnd_key, rnd_last);
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one block from an IDLE negedge; returns on the negedge after ready is back.
    task automatic do_block(input logic [127:0] p, input logic [127:0] k, input logic [127:0] v,
                            input bit abort_too, input string tag);
        int lat;
        logic [1407:0] exp_rk;
        exp_rk = expand(k);
        h.plaintext = p; h.key = k; h.iv = v; h.start = 1'b1; h.abort = abort_too;
        @(negedge clk);
        h.start = 1'b0; h.abort = 1'b0;
        h.plaintext = ~p; h.key = ~k; h.iv = ~v;
        chk({tag, "_busy"}, 256'(h.busy), 256'(1));
        lat = -1;
        for (int c = 0; c < 30 && lat < 0; c++) begin
            if (h.done) begin
                lat = c;
            end else begin
                if (c < 10) begin
                    chk($sformatf("%s_rkey%0d", tag, c), 256'(rnd_key), 256'(exp_rk[c*128 +: 128]));
                    chk($sformatf("%s_last%0d", tag, c), 256'(rnd_last), 256'(c == 9));
                    chk($sformatf("%s_keyout%0d", tag, c), 256'(key_out), 256'(k));
                end
                @(negedge clk);
            end
        end
        chk({tag, "_latency"}, 256'(lat), 256'(10));
        chk({tag, "_ct"}, 256'(h.ciphertext), 256'(aes_encrypt(p, k, v)));
        chk({tag, "_bundle"}, h.cipher_bundle, {v, aes_encrypt(p, k, v)});
        @(negedge clk);
        chk({tag, "_pulse"}, 256'(h.done), 256'(0));
        chk({tag, "_ready"}, 256'(h.ready), 256'(1));
    endtask

    initial begin
        logic [7:0]   inv;
        logic [127:0] acc_pt  [4];
        logic [127:0] acc_key [4];
        int           acc_idx [4];
        int           busy_cnt [4];
        int           n, nd, key_bad, dones;
        logic [127:0] exp_last;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                          ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
        sbox_ok = 1'b1;

        rst = 1'b0;
        h.start = 1'b0; h.abort = 1'b0;
        h.plaintext = '0; h.key = '0; h.iv = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 256'(h.ready), 256'(1));
        chk("rst_busy", 256'(h.busy), 256'(0));
        chk("rst_done", 256'(h.done), 256'(0));
        chk("rst_last", 256'(rnd_last), 256'(0));
        chk("rst_ct", 256'(h.ciphertext), 256'(0));
        rst = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1 known answer
        do_block(PT_C1, KEY_C1, 128'h0, 1'b0, "c1");
        chk("c1_kat", 256'(h.ciphertext), 256'(CT_C1));
        chk("c1_kat_bundle", h.cipher_bundle, {128'h0, CT_C1});

        // Same block entering through the IV whitening path
        do_block(128'h0, KEY_C1, PT_C1, 1'b0, "ivw");
        chk("ivw_kat", 256'(h.ciphertext), 256'(CT_C1));
        chk("ivw_ivout", 256'(h.iv_out), 256'(PT_C1));

        // start held high with inputs changing every cycle
        n = 0; nd = 0; key_bad = 0;
        for (int i = 0; i < 4; i++) begin acc_idx[i] = -1; busy_cnt[i] = 0; end
        for (int i = 0; i < 36; i++) begin
            h.start = 1'b1;
            h.iv = '0;
            h.plaintext = PT_C1 ^ {4{32'(i)}};
            h.key = KEY_C1 ^ {96'h0, 32'(i * 7 + 1)};
            if (h.busy && n > 0) begin
                busy_cnt[n-1]++;
                if (key_out !== acc_key[n-1]) key_bad++;
            end
            if (h.done && n > 0) begin
                nd++;
                chk($sformatf("hs_ct%0d", nd), 256'(h.ciphertext),
                    256'(aes_encrypt(acc_pt[n-1], acc_key[n-1], 128'h0)));
            end
            if (h.ready && n < 4) begin
                acc_idx[n] = i; acc_pt[n] = h.plaintext; acc_key[n] = h.key;
                n++;
            end
            @(negedge clk);
        end
        h.start = 1'b0;
        chk("hs_accepts", 256'(n), 256'(3));
        chk("hs_acc0", 256'(acc_idx[0]), 256'(0));
        chk("hs_acc1", 256'(acc_idx[1]), 256'(12));
        chk("hs_acc2", 256'(acc_idx[2]), 256'(24));
        chk("hs_dones", 256'(nd), 256'(3));
        chk("hs_busy0", 256'(busy_cnt[0]), 256'(10));
        chk("hs_busy1", 256'(busy_cnt[1]), 256'(10));
        chk("hs_busy2", 256'(busy_cnt[2]), 256'(10));
        chk("hs_keyout_stable", 256'(key_bad), 256'(0));
        exp_last = aes_encrypt(acc_pt[2], acc_key[2], 128'h0);

        // Abort at rnd=4
        h.plaintext = 128'h1; h.key = KEY_C1; h.iv = '0; h.start = 1'b1;
        @(negedge clk);
        h.start = 1'b0;
        repeat (4) @(negedge clk);
        h.abort = 1'b1;
        @(negedge clk);
        h.abort = 1'b0;
        chk("ab4_ready", 256'(h.ready), 256'(1));
        chk("ab4_busy", 256'(h.busy), 256'(0));
        chk("ab4_ct", 256'(h.ciphertext), 256'(exp_last));
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (h.done) dones++;
            @(negedge clk);
        end
        chk("ab4_nodone", 256'(dones), 256'(0));

        // Abort on the final round
        h.plaintext = 128'h2; h.key = KEY_C1; h.iv = '0; h.start = 1'b1;
        @(negedge clk);
        h.start = 1'b0;
        repeat (9) @(negedge clk);
        chk("ab9_last", 256'(rnd_last), 256'(1));
        h.abort = 1'b1;
        @(negedge clk);
        h.abort = 1'b0;
        chk("ab9_ready", 256'(h.ready), 256'(1));
        chk("ab9_done", 256'(h.done), 256'(0));
        chk("ab9_ct", 256'(h.ciphertext), 256'(exp_last));

        // start and abort together in IDLE: start wins, block completes
        do_block(PT_C1, KEY_C1, 128'h0, 1'b1, "abst");
        chk("abst_kat", 256'(h.ciphertext), 256'(CT_C1));

        // Asynchronous reset at rnd=6, between edges
        h.plaintext = 128'h3; h.key = ~KEY_C1; h.iv = 128'h5; h.start = 1'b1;
        @(negedge clk);
        h.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_ready", 256'(h.ready), 256'(1));
        chk("arst_busy", 256'(h.busy), 256'(0));
        chk("arst_last", 256'(rnd_last), 256'(0));
        chk("arst_ct", 256'(h.ciphertext), 256'(0));
        chk("arst_ivout", 256'(h.iv_out), 256'(0));
        chk("arst_keyout", 256'(key_out), 256'(0));
        chk("arst_state", 256'(rnd_state), 256'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_block(PT_C1, KEY_C1, 128'h0, 1'b0, "post_rst");
        chk("post_rst_kat", 256'(h.ciphertext), 256'(CT_C1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Iterative sequencer for one shared, combinational AES-128 round unit and the key-expansion network. It accepts a block on a start/ready handshake and computes the initial whitening, plaintext ^ key ^ iv. It then steps the round unit through rounds 1-10, one round per clock, and registers the ciphertext and the {iv, ciphertext} bundle. It replaces the ten-instance unrolled round chain with a single round instance, trading 10 cycles of latency for area.

## Interface
Parameters:
- NR, 10, number of rounds; fixed for AES-128; any other value is unsupported.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; accepted only when ready=1
- ready  out  1  high in IDLE only
- abort  in  1  synchronous cancel of an in-flight block
- plaintext  in  128  sampled on accepted start
- key  in  128  sampled on accepted start
- iv  in  128  sampled on accepted start, from the IV LFSR
- key_out  out  128  captured key, drives key expansion input
- round_keys  in  1408  from key expansion; slice i = round_keys[i*128 +: 128]
- rnd_state  out  128  state register, drives round unit state_in
- rnd_key  out  128  round_keys slice selected by round counter
- rnd_last  out  1  drives round unit last_round
- rnd_result  in  128  round unit state_out
- busy  out  1  high in ROUND
- done  out  1  one-cycle completion pulse
- ciphertext  out  128  registered result, held until next completion
- iv_out  out  128  captured IV
- cipher_bundle  out  256  {iv_out, ciphertext}

## Operation
- FSM states: IDLE, ROUND, DONE. rnd is a 4-bit counter, 0..9.
- IDLE, start=1:
  - state_reg <= plaintext ^ key ^ iv; key_reg <= key; iv_reg <= iv; rnd <= 0.
  - Go to ROUND.
- IDLE, start=0: hold all registers.
- ROUND:
  - Each edge: state_reg <= rnd_result.
  - If rnd==NR-1: ciphertext <= rnd_result; go to DONE.
  - Otherwise: rnd <= rnd+1.
- DONE: done=1 for this cycle; next edge go to IDLE.
- Combinational outputs:
  - rnd_state = state_reg.
  - rnd_key = round_keys[rnd*128 +: 128].
  - rnd_last = (state==ROUND && rnd==NR-1).
- key_out = key_reg, so round_keys stay stable while busy, independent of the key input.
- ciphertext and iv_out update only on completion (DONE entry) and accept (IDLE start) respectively.
  - cipher_bundle for an accepted block is consistent from the DONE cycle onward.
  - iv_out reflects the newest accepted block; cipher_bundle pairs iv_out with ciphertext. Consumers latch the bundle on done.
- start outside IDLE is ignored; nothing is queued.
- abort:
  - In ROUND: next edge go to IDLE, rnd <= 0. No done; ciphertext is unchanged.
  - abort has priority over completion, including when rnd==NR-1.
  - In IDLE or DONE: no effect. start and abort both high in IDLE: start wins.
- Reset (async assert, any state):
  - State to IDLE; rnd, state_reg, key_reg, iv_reg, ciphertext all 0.
  - ready=1, busy=0, done=0, rnd_last=0.

## Timing
- Accept edge E0 (IDLE, start=1).
- Rounds 1..10 complete at edges E1..E10. rnd=k is visible in the cycle after E(k), with rnd=0 after E0.
- done=1 and the new ciphertext are visible in the cycle after E10. ready returns after E11.
- Start-to-done latency is 10 cycles. Back-to-back throughput is one block per 12 cycles (next accept at E12).
- The round-unit path (rnd_state -> rnd_result) plus the key mux is the single-cycle critical path. There is no multicycle allowance.
- Reset deassertion is synchronized externally; the first accept is permitted on the first edge after release.

## Test plan
- FIPS-197 C.1 vector:
  - Stimulus: key=000102030405060708090a0b0c0d0e0f, plaintext=00112233445566778899aabbccddeeff, iv=0.
  - Required: ciphertext=69c4e0d86a7b0430d8cdb78070b4c55a, done exactly 10 cycles after accept, single-cycle pulse.
  - Required: cipher_bundle={128'h0, 69c4e0d8...c55a}.
- IV whitening:
  - Stimulus: same key, iv=00112233445566778899aabbccddeeff, plaintext=0.
  - Required: same ciphertext 69c4e0d8...c55a; iv_out=iv.
- Handshake:
  - Hold start=1 continuously with changing plaintext.
  - Required: accepts only at E0, E12, E24. busy=1 for exactly 10 cycles each. Inputs changed mid-block do not alter the result. key changed mid-block does not alter key_out.
- Abort:
  - Pulse abort at rnd=4; separately at rnd=9.
  - Required: no done, IDLE next cycle, ciphertext keeps its previous value, next block computes correctly.
- Reset mid-operation:
  - Assert rst=0 at rnd=6 between edges.
  - Required: outputs go to reset values immediately without a clock; after release, the C.1 vector passes.
- Round sequencing:
  - Monitor rnd_key and rnd_last.
  - Required: rnd_key equals round_keys slices 0..9 in order. rnd_last is high only in the 10th ROUND cycle.
